// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider: per channel a flop-driven divided
// clock, a first-cycle-of-period tick, and a running flag; divisors change at period boundaries.
module clk_div_multi #(
    parameter  int NCH   = 4,
    parameter  int DIV_W = 16,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic             cfg_en,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             sync,
    output logic [NCH-1:0]   CLK_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   running
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    // Divisors below 2 cannot form a high and a low phase, so they run as 2.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t           state_q, state_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] act_q, act_d;
        logic [DIV_W-1:0] pend_q, pend_d;
        logic             pv_q, pv_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic [DIV_W-1:0] half_hi;
        logic             wr_sel;

        // Out-of-range channel indices never match any g, so such writes are dropped.
        assign wr_sel = cfg_we && (32'(cfg_ch) == g);

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            act_d   = act_q;
            pend_d  = pend_q;
            pv_d    = pv_q;
            if (state_q == S_RUN) begin
                if (sync || (cnt_q == act_q - DIV_W'(1))) begin
                    cnt_d = '0;
                    if (pv_q) begin
                        act_d = pend_q;
                        pv_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            if (wr_sel) begin
                if (!cfg_en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    pv_d    = 1'b0;
                end else if (state_q == S_IDLE) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    act_d   = clamp_div(cfg_div);
                    pv_d    = 1'b0;
                end else if (sync) begin
                    cnt_d   = '0;
                    act_d   = clamp_div(cfg_div);
                    pv_d    = 1'b0;
                end else begin
                    pend_d  = clamp_div(cfg_div);
                    pv_d    = 1'b1;
                end
            end
            // Outputs are registered, so they are derived from the next count and divisor.
            half_hi = (act_d >> 1) + DIV_W'(act_d[0]);
            clk_d   = (state_d == S_RUN) && (cnt_d < half_hi);
            tick_d  = (state_d == S_RUN) && (cnt_d == '0);
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                act_q   <= DIV_W'(2);
                pend_q  <= DIV_W'(2);
                pv_q    <= 1'b0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                act_q   <= act_d;
                pend_q  <= pend_d;
                pv_q    <= pv_d;
                clk_q   <= clk_d;
                tick_q  <= tick_d;
            end
        end

        assign CLK_out[g] = clk_q;
        assign tick[g]    = tick_q;
        assign running[g] = (state_q == S_RUN);
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Multi-channel, runtime-programmable clock divider that supersedes the fixed single-DIV divider. Each of NCH channels produces a flop-driven divided clock, a one-cycle tick, and a running flag from the system clock. Divisors are written through a simple config port and take effect glitch-free at period boundaries. A global sync input phase-aligns all running channels.

Parameters:
NCH, 4, number of divider channels (1..16)
DIV_W, 16, divisor width in bits; max divisor 2^DIV_W-1
CH_W, $clog2(NCH) (min 1), channel-select width (derived, not overridden)

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
cfg_we  in  1  config write strobe, sampled on CLK edge
cfg_ch  in  CH_W  channel index for the write
cfg_en  in  1  1 = enable channel / update divisor; 0 = disable channel
cfg_div  in  DIV_W  divisor D for the write
sync  in  1  single-cycle request to restart all running channels at phase 0
CLK_out  out  NCH  divided clock per channel, each bit driven directly by a flop
tick  out  NCH  one-cycle pulse on the first cycle of each period, flop-driven
running  out  NCH  1 while the channel is in RUN

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST).
- Per-channel state: IDLE/RUN, cnt[DIV_W], active div A, pending div P, pending flag pv.
- Divisor clamp: written D of 0 or 1 is stored as 2. H = ceil(A/2), L = floor(A/2); high phase H cycles, low phase L cycles, period A.
- RUN output rule: in a cycle where cnt==c, CLK_out=(c<H) and tick=(c==0). cnt goes 0..A-1, then wraps to 0.
- IDLE: CLK_out=0, tick=0, running=0, cnt held at 0.
- RST (at any time, including mid-period): all channels IDLE and all outputs 0 in the cycle after the edge. Also pv=0, A=P=2. Config and sync are ignored while RST=1.
- Write to an IDLE channel with cfg_en=1: the next cycle is RUN with cnt=0, A=clamp(cfg_div), CLK_out=1, tick=1, running=1. Start latency is 1 cycle.
- Write to a RUN channel with cfg_en=1: set P=clamp(cfg_div), pv=1. The current period completes unchanged. At the wrap (cnt==A-1 -> 0), A<=P and pv<=0. A later write before the wrap overwrites P (last write wins).
- Write with cfg_en=0: the next cycle is IDLE, outputs 0, pv cleared. Disable is immediate and may truncate a high phase; this is accepted.
- cfg_ch >= NCH: the write is ignored and no state changes.
- sync=1: every RUN channel has cnt=0 next cycle (CLK_out=1, tick=1). A pending P is applied at that restart. IDLE channels are unaffected.
- sync and a write to the same channel in the same cycle:
  - Write with cfg_en=0 wins: channel goes IDLE.
  - Write with cfg_en=1 to a RUN channel: channel restarts with the newly written divisor.
  - Write with cfg_en=1 to an IDLE channel: channel starts as a normal enable.
- A=2^DIV_W-1: cnt never overflows. Wrap compare uses A-1 at full DIV_W width.
- Channels are fully independent apart from sync and the shared config port.

Test Plan:
- Bench setup for all scenarios: CLK period 5 ns, RST high for 2 cycles, then release.
- Enable ch0 with D=2 -> CLK_out[0] reads 1,0,1,0… (10 ns period), starting 1 cycle after the write. tick[0] is high every 2nd cycle, aligned with each CLK_out rise.
- Enable ch1 with D=5 -> CLK_out[1] is high 3 cycles, low 2 cycles (25 ns period). tick[1] fires every 5 cycles. running[1]=1.
- Ch1 running at D=5, write D=3 when cnt==1 -> the current period still lasts 5 cycles total (3 high, 2 low). Afterwards the pattern is high 2, low 1, repeating with tick every 3 cycles.
- Ch0 at D=4 and ch2 at D=6, started at different phases. Pulse sync -> next cycle tick[0] and tick[2] are both 1 and both CLK_out are 1. Coincident ticks then recur every 12 cycles.
- Write D=0 and D=1 to ch3 -> behaves as D=2. With NCH=3 build, write cfg_ch=3 -> no channel changes state.
- Ch1 at D=5: drop cfg_en=0 mid-high -> next cycle all of ch1's outputs are 0. Repeat the run and instead assert RST mid-run -> next cycle all CLK_out, tick and running are 0. The old divisor is not resumed until rewritten; after re-enable, a pending divisor from before reset is not applied.
